// File: rtl/tensor_pkg.sv
// Shared constants and state types for the tensor ping-pong buffer and the
// peak detector that consumes its banks.
package tensor_pkg;

    localparam int DATA_W = 8;
    localparam int GRID_W = 32;
    localparam int GRID_H = 32;
    localparam int ADDR_W = $clog2(GRID_W * GRID_H);

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2,
        READING = 2'd3
    } bank_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_BUSY = 1'b1
    } rd_state_t;

endpackage

// File: rtl/tensor_bank_ram.sv
// One tensor bank: simple dual-port RAM (one write port, one read port) with a
// registered read. The read register clears on reset so rdata starts at zero.
module tensor_bank_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Storage array: contents are deliberately left uninitialised on reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Registered read port, one cycle of latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/tensor_pingpong_buffer.sv
// Ping-pong tensor buffer: fills one 32x32 bank from a raster score stream
// while the peak detector scans the other. Completed banks are published in
// fill order with a one-cycle tensor_valid pulse.
// Optional feature macro: TENSOR_LAST_CHECK_EN (s_last framing check, frame_err).
module tensor_pingpong_buffer
    import tensor_pkg::*;
#(
    parameter int DATA_W = tensor_pkg::DATA_W,
    parameter int GRID_W = tensor_pkg::GRID_W,
    parameter int GRID_H = tensor_pkg::GRID_H,
    parameter int ADDR_W = tensor_pkg::ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_data,
    input  logic                     s_last,
    output logic                     tensor_valid,
    input  logic        [ADDR_W-1:0] raddr,
    output logic signed [DATA_W-1:0] rdata,
    input  logic                     rd_done,
    output logic                     frame_err
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(GRID_W * GRID_H - 1);

    bank_state_t       bankState_q [2];
    bank_state_t       bankState_d [2];
    logic              wrBank_q, wrBank_d;
    logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
    rd_state_t         rdState_q, rdState_d;
    logic              rdBank_q, rdBank_d;
    logic              rdBankDly_q;
    logic              readyEn_q;

    logic              wrFire;
    logic              atLast;
    logic              frameBad;
    logic              pickBank;
    logic              pubEn;
    logic              relEn;
    logic [DATA_W-1:0] bankRdata [2];

    assign s_ready = readyEn_q &&
                     (bankState_q[wrBank_q] == FREE || bankState_q[wrBank_q] == FILLING);
    assign wrFire  = s_valid && s_ready;
    assign atLast  = (wrPtr_q == LAST_PTR);

    // When both banks are FULL the writer is parked on the older one, so the
    // writer's bank is the oldest full bank whenever it is FULL at all.
    assign pickBank = (bankState_q[wrBank_q] == FULL) ? wrBank_q : ~wrBank_q;

`ifdef TENSOR_LAST_CHECK_EN
    logic frameErr_q, frameErr_d;

    assign frameBad   = wrFire && (s_last != atLast);
    assign frameErr_d = frameErr_q | frameBad;

    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frameErr_q <= 1'b0;
        end else begin
            frameErr_q <= frameErr_d;
        end
    end

    assign frame_err = frameErr_q;
`else
    logic unusedLast;

    assign unusedLast = s_last;
    assign frameBad   = 1'b0;
    assign frame_err  = 1'b0;
`endif

    // Reader FSM: publish the oldest full bank when idle, release it on rd_done.
    always_comb begin
        rdState_d    = rdState_q;
        rdBank_d     = rdBank_q;
        tensor_valid = 1'b0;
        pubEn        = 1'b0;
        relEn        = 1'b0;
        case (rdState_q)
            R_IDLE: begin
                if (bankState_q[pickBank] == FULL) begin
                    pubEn        = 1'b1;
                    tensor_valid = 1'b1;
                    rdBank_d     = pickBank;
                    rdState_d    = R_BUSY;
                end
            end
            R_BUSY: begin
                if (rd_done) begin
                    relEn     = 1'b1;
                    rdState_d = R_IDLE;
                end
            end
            default: rdState_d = R_IDLE;
        endcase
    end

    // Bank bookkeeping: the reader only touches FULL/READING banks and the
    // writer only FREE/FILLING ones, so their updates never collide.
    always_comb begin
        bankState_d = bankState_q;
        wrBank_d    = wrBank_q;
        wrPtr_d     = wrPtr_q;
        if (relEn) begin
            bankState_d[rdBank_q] = FREE;
        end
        if (pubEn) begin
            bankState_d[pickBank] = READING;
        end
        if (wrFire) begin
            if (frameBad) begin
                bankState_d[wrBank_q] = FREE;
                wrPtr_d               = '0;
            end else if (atLast) begin
                bankState_d[wrBank_q] = FULL;
                wrPtr_d               = '0;
                wrBank_d              = ~wrBank_q;
            end else begin
                bankState_d[wrBank_q] = FILLING;
                wrPtr_d               = wrPtr_q + 1'b1;
            end
        end
    end

    // State registers; a reset discards any partial or unread bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bankState_q[0] <= FREE;
            bankState_q[1] <= FREE;
            wrBank_q       <= 1'b0;
            wrPtr_q        <= '0;
            rdState_q      <= R_IDLE;
            rdBank_q       <= 1'b0;
            rdBankDly_q    <= 1'b0;
            readyEn_q      <= 1'b0;
        end else begin
            bankState_q <= bankState_d;
            wrBank_q    <= wrBank_d;
            wrPtr_q     <= wrPtr_d;
            rdState_q   <= rdState_d;
            rdBank_q    <= rdBank_d;
            rdBankDly_q <= rdBank_q;
            readyEn_q   <= 1'b1;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : gBank
        tensor_bank_ram #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) uRam (
            .clk     (clk),
            .reset   (reset),
            .we_i    (wrFire && (wrBank_q == 1'(b))),
            .waddr_i (wrPtr_q),
            .wdata_i (s_data),
            .raddr_i (raddr),
            .rdata_o (bankRdata[b])
        );
    end

    assign rdata = bankRdata[rdBankDly_q];

endmodule
